// File: rtl/glb_block_sender.sv
// glb_block_sender: emits NUM_BLOCKS length-prefixed blocks of 16-bit words from preloaded buffers.
// Optional per-block XOR trailer word: define GLB_BLOCK_SENDER_CHECKSUM_EN.
//
// state | meaning
// IDLE  | waiting for start, buffer writes allowed
// HDR   | presenting clamped size of current block
// PAY   | presenting payload word idx of current block
// TRL   | presenting XOR checksum of current block (checksum build only)
// FIN   | one cycle with done set, back to IDLE
module glb_block_sender #(
    parameter int NUM_BLOCKS = 1,
    parameter int DEPTH      = 1024
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic                     wr_blk,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [15:0]              wr_data,
    input  logic [15:0]              size_0,
    input  logic [15:0]              size_1,
    input  logic                     start,
    output logic [15:0]              data,
    output logic                     valid,
    input  logic                     ready,
    output logic                     busy,
    output logic                     done
);

    localparam int AW  = $clog2(DEPTH);
    localparam int MAW = $clog2(NUM_BLOCKS * DEPTH);
    localparam int unsigned DEPTH_U = DEPTH;
    localparam logic [AW:0] IDX_ONE = {{AW{1'b0}}, 1'b1};

    typedef enum logic [2:0] {IDLE, HDR, PAY, TRL, FIN} state_t;

    state_t          state_q, state_d;
    logic            blk_q, blk_d;
    logic [AW:0]     idx_q, idx_d;
    logic [AW:0]     size0_q, size0_d;
    logic [AW:0]     size1_q, size1_d;
    logic            done_q, done_d;
    logic [15:0]     csum_q, csum_d;
    logic [AW:0]     size_cur;
    logic            hs, last_blk, wr_ok, eob, adv;
    logic [15:0]     rd_q;
    logic [MAW-1:0]  rd_maddr, wr_maddr;
    logic [15:0]     mem [NUM_BLOCKS*DEPTH];

    function automatic logic [AW:0] clamp_size(input logic [15:0] s);
        if ({16'd0, s} > DEPTH_U) return DEPTH_U[AW:0];
        return s[AW:0];
    endfunction

    assign valid    = (state_q == HDR) || (state_q == PAY) || (state_q == TRL);
    assign busy     = valid;
    assign done     = done_q;
    assign hs       = valid && ready;
    assign size_cur = blk_q ? size1_q : size0_q;
    assign last_blk = (NUM_BLOCKS != 2) || blk_q;
    assign wr_ok    = wr_en && ((state_q == IDLE) || (state_q == FIN))
                      && ((NUM_BLOCKS == 2) || !wr_blk);

    always_comb begin
        state_d = state_q;
        blk_d   = blk_q;
        idx_d   = idx_q;
        size0_d = size0_q;
        size1_d = size1_q;
        done_d  = done_q;
        csum_d  = csum_q;
        eob     = 1'b0;
        adv     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    size0_d = clamp_size(size_0);
                    size1_d = clamp_size(size_1);
                    done_d  = 1'b0;
                    blk_d   = 1'b0;
                    idx_d   = '0;
                    csum_d  = '0;
                    state_d = HDR;
                end
            end
            HDR: begin
                if (hs) begin
                    idx_d = '0;
                    if (size_cur == '0) eob = 1'b1;
                    else state_d = PAY;
                end
            end
            PAY: begin
                if (hs) begin
                    csum_d = csum_q ^ rd_q;
                    idx_d  = idx_q + IDX_ONE;
                    if (idx_d == size_cur) eob = 1'b1;
                end
            end
            TRL:     adv = hs;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
`ifdef GLB_BLOCK_SENDER_CHECKSUM_EN
        if (eob) state_d = TRL;
`else
        adv = adv | eob;
`endif
        if (adv) begin
            if (last_blk) begin
                state_d = FIN;
                done_d  = 1'b1;
            end else begin
                state_d = HDR;
                blk_d   = 1'b1;
                idx_d   = '0;
                csum_d  = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            blk_q   <= 1'b0;
            idx_q   <= '0;
            size0_q <= '0;
            size1_q <= '0;
            done_q  <= 1'b0;
            csum_q  <= '0;
        end else begin
            state_q <= state_d;
            blk_q   <= blk_d;
            idx_q   <= idx_d;
            size0_q <= size0_d;
            size1_q <= size1_d;
            done_q  <= done_d;
            csum_q  <= csum_d;
        end
    end

    // Read address follows the next-cycle index, so the RAM output always holds
    // the word PAY will present (and re-reads it while the channel stalls).
    if (NUM_BLOCKS == 2) begin : g_two
        assign rd_maddr = {blk_d, idx_d[AW-1:0]};
        assign wr_maddr = {wr_blk, wr_addr};
    end else begin : g_one
        assign rd_maddr = idx_d[AW-1:0];
        assign wr_maddr = wr_addr;
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_maddr] <= wr_data;
        rd_q <= mem[rd_maddr];
    end

    always_comb begin
        data = 16'd0;
        case (state_q)
            HDR:     data = 16'(size_cur);
            PAY:     data = rd_q;
            TRL:     data = csum_q;
            default: data = 16'd0;
        endcase
    end

endmodule

// File: tb/tb_glb_block_sender.sv
// Bench for glb_block_sender: one single-block and one two-block instance checked
// against a queue model built from shadow buffers.
module tb_glb_block_sender;

    localparam int DEPTH = 1024;
    localparam int AW    = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_en = 1'b0;
    logic          wr_blk = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [15:0]   wr_data = 16'd0;
    logic [15:0]   size_0 = 16'd0;
    logic [15:0]   size_1 = 16'd0;
    logic          start1 = 1'b0;
    logic          start2 = 1'b0;
    logic          ready = 1'b0;
    logic [15:0]   data1, data2;
    logic          valid1, valid2, busy1, busy2, done1, done2;

    bit            sel = 1'b0;
    logic [15:0]   c_data;
    logic          c_valid, c_busy, c_done;

    int            checks = 0;
    int            errors = 0;
    logic [15:0]   mb [2][DEPTH];
    logic [15:0]   exp_q [$];

    always #5 clk = ~clk;

    assign c_data  = sel ? data2  : data1;
    assign c_valid = sel ? valid2 : valid1;
    assign c_busy  = sel ? busy2  : busy1;
    assign c_done  = sel ? done2  : done1;

    glb_block_sender #(.NUM_BLOCKS(1), .DEPTH(DEPTH)) u1 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_blk(wr_blk), .wr_addr(wr_addr),
        .wr_data(wr_data), .size_0(size_0), .size_1(size_1), .start(start1),
        .data(data1), .valid(valid1), .ready(ready), .busy(busy1), .done(done1)
    );

    glb_block_sender #(.NUM_BLOCKS(2), .DEPTH(DEPTH)) u2 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_blk(wr_blk), .wr_addr(wr_addr),
        .wr_data(wr_data), .size_0(size_0), .size_1(size_1), .start(start2),
        .data(data2), .valid(valid2), .ready(ready), .busy(busy2), .done(done2)
    );

    task automatic write_word(input bit blk, input int addr, input logic [15:0] d);
        @(posedge clk); #1;
        wr_en = 1'b1; wr_blk = blk; wr_addr = addr[AW-1:0]; wr_data = d;
        mb[blk][addr] = d;
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    // Expected stream: per block, clamped size then that many buffer words (+ XOR trailer).
    task automatic build_exp(input int nb, input int s0, input int s1);
        int sz;
        logic [15:0] x;
        exp_q.delete();
        for (int b = 0; b < nb; b++) begin
            sz = (b == 0) ? s0 : s1;
            if (sz > DEPTH) sz = DEPTH;
            exp_q.push_back(16'(sz));
            x = 16'd0;
            for (int i = 0; i < sz; i++) begin
                exp_q.push_back(mb[b][i]);
                x = x ^ mb[b][i];
            end
`ifdef GLB_BLOCK_SENDER_CHECKSUM_EN
            exp_q.push_back(x);
`endif
        end
    endtask

    task automatic launch(input bit s);
        sel = s;
        @(posedge clk); #1;
        if (s) start2 = 1'b1; else start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0; start2 = 1'b0;
    endtask

    // pulse: 0 none, 1 extra start at cycle 20, 2 extra start while the last word is offered
    task automatic run_stream(input bit rnd, input int pulse, input string name);
        int cyc = 0;
        bit held = 1'b0;
        logic [15:0] hd = 16'd0;
        logic [15:0] e;
        while (exp_q.size() > 0 && cyc < 4000) begin
            ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if ((pulse == 1 && cyc == 20) || (pulse == 2 && exp_q.size() == 1)) begin
                if (sel) start2 = 1'b1; else start1 = 1'b1;
            end
            @(negedge clk);
            cyc++;
            checks++;
            if (c_busy !== 1'b1) begin
                errors++;
                $display("FAIL %s busy cyc=%0d act=%b exp=1", name, cyc, c_busy);
            end
            if (held) begin
                checks++;
                if (c_valid !== 1'b1 || c_data !== hd) begin
                    errors++;
                    $display("FAIL %s hold cyc=%0d act=%b/%h exp=1/%h", name, cyc, c_valid, c_data, hd);
                end
            end
            held = 1'b0;
            if (c_valid === 1'b1 && ready) begin
                e = exp_q.pop_front();
                checks++;
                if (c_data !== e) begin
                    errors++;
                    $display("FAIL %s data cyc=%0d act=%h exp=%h", name, cyc, c_data, e);
                end
            end else if (c_valid === 1'b1) begin
                held = 1'b1;
                hd = c_data;
            end else begin
                checks++;
                errors++;
                $display("FAIL %s valid cyc=%0d act=%b exp=1", name, cyc, c_valid);
            end
            @(posedge clk); #1;
            start1 = 1'b0; start2 = 1'b0;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s timeout act=%0d left exp=0", name, exp_q.size());
        end
        @(negedge clk);
        checks++;
        if (c_valid !== 1'b0 || c_busy !== 1'b0 || c_done !== 1'b1) begin
            errors++;
            $display("FAIL %s end act=v%b b%b d%b exp=v0 b0 d1", name, c_valid, c_busy, c_done);
        end
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (c_valid !== 1'b0 || c_done !== 1'b1) begin
                errors++;
                $display("FAIL %s idle act=v%b d%b exp=v0 d1", name, c_valid, c_done);
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({valid1, busy1, done1, valid2, busy2, done2} !== 6'b0 || data1 !== 16'd0 || data2 !== 16'd0) begin
            errors++;
            $display("FAIL reset_in act=%b%b%b%b%b%b %h %h exp=0", valid1, busy1, done1, valid2, busy2, done2, data1, data2);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({valid1, busy1, done1, valid2, busy2, done2} !== 6'b0 || data1 !== 16'd0) begin
            errors++;
            $display("FAIL reset_out act=%b%b%b%b%b%b %h exp=0", valid1, busy1, done1, valid2, busy2, done2, data1);
        end
    endtask

    task automatic test_single();
        for (int i = 0; i < 5; i++) write_word(1'b0, i, 16'hA000 + 16'(i));
        size_0 = 16'd5;
        build_exp(1, 5, 0);
        launch(1'b0);
        run_stream(1'b0, 0, "single");
    endtask

    task automatic test_two_block();
        for (int i = 0; i < 3; i++) write_word(1'b1, i, 16'($urandom));
        size_0 = 16'd0;
        size_1 = 16'd3;
        build_exp(2, 0, 3);
        launch(1'b1);
        run_stream(1'b0, 0, "two_block");
    endtask

    task automatic test_ready_random();
        size_0 = 16'd5;
        build_exp(1, 5, 0);
        launch(1'b0);
        run_stream(1'b1, 0, "rand_ready_a");
        for (int it = 0; it < 4; it++) begin
            int s0, s1;
            s0 = $urandom_range(1, 8);
            s1 = $urandom_range(0, 8);
            for (int i = 0; i < s0; i++) write_word(1'b0, i, 16'($urandom));
            for (int i = 0; i < s1; i++) write_word(1'b1, i, 16'($urandom));
            size_0 = 16'(s0);
            size_1 = 16'(s1);
            build_exp(it[0] ? 2 : 1, s0, s1);
            launch(it[0]);
            run_stream(1'b1, 2, "rand_ready_b");
        end
    endtask

    task automatic test_clamp();
        for (int i = 0; i < DEPTH; i++) write_word(1'b0, i, 16'($urandom));
        size_0 = 16'd2000;
        build_exp(1, 2000, 0);
        launch(1'b0);
        run_stream(1'b0, 1, "clamp");
    endtask

    task automatic test_reset_mid();
        size_0 = 16'd5;
        launch(1'b0);
        ready = 1'b1;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (valid1 !== 1'b0 || busy1 !== 1'b0 || done1 !== 1'b0 || data1 !== 16'd0) begin
            errors++;
            $display("FAIL reset_mid act=v%b b%b d%b %h exp=0", valid1, busy1, done1, data1);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        build_exp(1, 5, 0);
        launch(1'b0);
        run_stream(1'b0, 0, "restart");
    endtask

    task automatic test_checksum();
        write_word(1'b0, 0, 16'h0001);
        write_word(1'b0, 1, 16'h0003);
        write_word(1'b0, 2, 16'h00F0);
        size_0 = 16'd3;
        build_exp(1, 3, 0);
        launch(1'b0);
        run_stream(1'b1, 0, "checksum");
    endtask

    initial begin
        test_reset();
        test_single();
        test_two_block();
        test_ready_random();
        test_clamp();
        test_reset_mid();
        test_checksum();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
